time_entry_loader: RTL and testbench
====================================

# time_entry_loader

Keypad time-entry front end for the microwave timer. It collects decimal key presses into a four-digit mm:ss buffer and validates the entry on start. It then drives the parallel `data`/`load` inputs of the four cascaded mod-10 down-counters and holds off further entry until the run ends or is cancelled. It is the writer side of the counters' load interface.

## Interface

Parameters:
- `NUM_DIGITS`, 4: buffer depth in BCD digits (min_tens, min_ones, sec_tens, sec_ones).
- `SEC_TENS_MAX`, 5: largest legal seconds-tens digit.

Ports:
- `clk`  in  1  single system clock, all state on rising edge.
- `clear`  in  1  reset; asynchronous, active-low. Forces the reset values below immediately.
- `key_valid`  in  1  one-cycle strobe: `key_digit` is a new key press.
- `key_digit`  in  4  key code; 0–9 legal, 10–15 illegal.
- `start`  in  1  one-cycle strobe: request to load the counters and run.
- `cancel`  in  1  one-cycle strobe: discard entry or abort run.
- `run_done`  in  1  level from timer control: all counters reached terminal count.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  buffer digits; these are the counters' `data` inputs.
- `load`  out  1  one-cycle pulse to all four counters' `load`.
- `running`  out  1  high while in LOCKED.
- `entry_count`  out  3  digits accepted since last clear/cancel/run end, 0..4.
- `err`  out  1  one-cycle pulse on any rejected key or start.
- `abort`  out  1  one-cycle pulse when cancel ends a run.

## Operation

- States: IDLE (buffer empty), ENTRY, LOAD, LOCKED.
- Reset values: state IDLE, all digits 0, `entry_count` 0, `load`/`running`/`err`/`abort` 0.
- Digit accept (IDLE or ENTRY, `key_valid`, `key_digit`≤9, `entry_count`<4):
  - Shift left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←key_digit.
  - `entry_count`+1; state ENTRY.
  - Leading zeros are accepted and counted.
- Digit reject: `key_digit`>9 or `entry_count`==4. Buffer unchanged, `err` pulses.
- Start in ENTRY:
  - If buffer ≠ 0000 and `sec_tens`≤SEC_TENS_MAX, go to LOAD.
  - Otherwise `err` pulses and the state and buffer are kept.
- Start in IDLE: `err` pulses.
- LOAD lasts exactly one cycle. `load`=1 during it, digits are stable, and all inputs are ignored. Next state is LOCKED.
- LOCKED: `running`=1, `key_valid` and `start` are ignored with no `err`.
  - `run_done` → IDLE; buffer cleared, `entry_count`=0.
- Cancel:
  - In ENTRY: clear buffer and `entry_count`, go to IDLE.
  - In LOCKED: same, plus `abort` pulses.
  - In IDLE or LOAD: no effect.
- Same-cycle priority: cancel > run_done > start > key_valid. The lower-priority event is dropped with no `err`.

## Timing

- All outputs are registered.
- Key accepted at edge N: digits and `entry_count` update after edge N. `err` is high in cycle N+1 only.
- Start accepted at edge N: `load`=1 in cycle N+1, `running`=1 from cycle N+2.
- The counters sample `data` on the rising edge that ends cycle N+1.
- Cancel at edge N in LOCKED: `running`=0 and `abort`=1 in cycle N+1.
- `clear` low mid-run: immediate return to reset values. No `abort` or `load` is produced.

## Structure

- Shared package `microwave_pkg`:
  - State enum (IDLE, ENTRY, LOAD, LOCKED).
  - Constants `NUM_DIGITS`=4, `DIGIT_MAX`=9, `SEC_TENS_MAX`=5.
  - BCD digit typedef (4 bits).
- Sub-module `digit_shift_reg`: 4×4-bit BCD shift register.
  - Inputs: shift-enable, sync-clear, serial digit.
  - Output: parallel digit bus.
- The FSM, validation and pulse generation live in the top module.

## Test plan

- Keys 1,3,0 then start → digits 0,1,3,0; `entry_count`=3; `load` high exactly one cycle with data 0130; `running`=1; `run_done` → IDLE with buffer 0000.
- Keys 1,2,3,4,5 → fifth key gives `err`; buffer stays 1234; `entry_count`=4.
- Key code 12 → `err`; buffer unchanged. Keys 0,9,9 then start (buffer 0099, sec_tens 9) → `err`, no `load`, state ENTRY.
- Start in IDLE, and keys 0,0 then start → `err` both times; `load` never asserted.
- Run 0010, then cancel while LOCKED → `abort` one cycle, `running`=0, buffer 0000. Keys and start during LOCKED produce no buffer change and no `err`.
- Same-cycle start and key 7 with buffer 0005 → `load` with data 0005, key dropped. Same-cycle cancel and start → IDLE, no `load`. `clear` low during LOAD → all outputs 0 immediately.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer front end.
//   - state_t : time-entry FSM states
//   - bcd_t   : one BCD digit
//   - NUM_DIGITS / DIGIT_MAX / SEC_TENS_MAX : entry buffer limits
//   - bcd_legal() : true for a key code that is a decimal digit
package microwave_pkg;

  localparam int NUM_DIGITS   = 4;
  localparam int DIGIT_MAX    = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Key codes 10..15 are the non-digit keys of the pad.
  function automatic logic bcd_legal(input bcd_t d);
    return (d <= bcd_t'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/time_entry_loader_digit_shift_reg.sv
// digit_shift_reg: BCD shift register holding the typed time.
// New digits enter at index 0 (seconds ones) and older digits move toward
// the top index (minutes tens), matching how a keypad entry reads left to right.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_shift_en     : shift in i_digit this cycle
//   i_sync_clr     : synchronous clear to all zeros (wins over shift)
//   i_digit        : serial digit in
//   o_digits       : parallel digit bus, [DEPTH-1] = most significant
module digit_shift_reg
  import microwave_pkg::*;
#(
  parameter int DEPTH = microwave_pkg::NUM_DIGITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_shift_en,
  input  logic                 i_sync_clr,
  input  bcd_t                 i_digit,
  output bcd_t [DEPTH-1:0]     o_digits
);

  bcd_t [DEPTH-1:0] r_digits;

  // Digit storage: clear has priority over shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digits <= '0;
    end else if (i_sync_clr) begin
      r_digits <= '0;
    end else if (i_shift_en) begin
      r_digits <= {r_digits[DEPTH-2:0], i_digit};
    end else begin
      r_digits <= r_digits;
    end
  end

  assign o_digits = r_digits;

endmodule

// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad time-entry front end for the microwave timer.
// Collects decimal keys into an mm:ss buffer, validates it on start, pulses
// `load` to the four cascaded down-counters and then locks out entry until the
// run ends (run_done) or is cancelled.
// Ports:
//   clk, clear             : clock, asynchronous active-low reset
//   key_valid, key_digit   : key strobe and key code (0..9 legal)
//   start, cancel          : one-cycle request strobes
//   run_done               : level, all counters at terminal count
//   min_tens..sec_ones     : buffer digits, the counters' data inputs
//   load                   : one-cycle counter load pulse
//   running                : high while the run is locked in
//   entry_count            : digits accepted since buffer was last emptied
//   err                    : one-cycle pulse on rejected key or start
//   abort                  : one-cycle pulse when cancel ends a run
module time_entry_loader
  import microwave_pkg::*;
#(
  parameter int NUM_DIGITS   = microwave_pkg::NUM_DIGITS,
  parameter int SEC_TENS_MAX = microwave_pkg::SEC_TENS_MAX
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       run_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       running,
  output logic [2:0] entry_count,
  output logic       err,
  output logic       abort
);

  state_t r_state;
  state_t w_next;

  logic [2:0] r_count;
  logic [2:0] w_count_next;
  logic       r_load;
  logic       r_running;
  logic       r_err;
  logic       r_abort;
  logic       w_err_next;
  logic       w_abort_next;
  logic       w_shift;
  logic       w_clr;
  logic       w_key_ok;
  logic       w_start_ok;

  bcd_t [NUM_DIGITS-1:0] w_digits;

  digit_shift_reg #(
    .DEPTH (NUM_DIGITS)
  ) u_digits (
    .i_clk      (clk),
    .i_rst_n    (clear),
    .i_shift_en (w_shift),
    .i_sync_clr (w_clr),
    .i_digit    (key_digit),
    .o_digits   (w_digits)
  );

  // A key is taken only if it is a digit and the buffer still has room.
  assign w_key_ok   = bcd_legal(key_digit) && (r_count < 3'(NUM_DIGITS));
  // Zero time cannot run; seconds tens above 5 is not a valid mm:ss.
  assign w_start_ok = (|w_digits) && (w_digits[1] <= bcd_t'(SEC_TENS_MAX));

  // Next-state and pulse decode; priority cancel > run_done > start > key.
  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_shift      = 1'b0;
    w_clr        = 1'b0;
    w_err_next   = 1'b0;
    w_abort_next = 1'b0;
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (cancel) begin
          // Cancel swallows any same-cycle start/key; only ENTRY has a buffer to drop.
          if (r_state == ST_ENTRY) begin
            w_clr        = 1'b1;
            w_count_next = 3'd0;
            w_next       = ST_IDLE;
          end else begin
            w_next = r_state;
          end
        end else if (start) begin
          if ((r_state == ST_ENTRY) && w_start_ok) begin
            w_next = ST_LOAD;
          end else begin
            w_err_next = 1'b1;
          end
        end else if (key_valid) begin
          if (w_key_ok) begin
            w_shift      = 1'b1;
            w_count_next = r_count + 3'd1;
            w_next       = ST_ENTRY;
          end else begin
            w_err_next = 1'b1;
          end
        end else begin
          w_next = r_state;
        end
      end
      ST_LOAD: begin
        // Digits are held for the counters' sampling edge; inputs ignored.
        w_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (cancel) begin
          w_clr        = 1'b1;
          w_count_next = 3'd0;
          w_abort_next = 1'b1;
          w_next       = ST_IDLE;
        end else if (run_done) begin
          w_clr        = 1'b1;
          w_count_next = 3'd0;
          w_next       = ST_IDLE;
        end else begin
          w_next = ST_LOCKED;
        end
      end
      default: begin
        w_clr        = 1'b1;
        w_count_next = 3'd0;
        w_next       = ST_IDLE;
      end
    endcase
  end

  // State, count and registered output pulses; outputs follow the next state.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state   <= ST_IDLE;
      r_count   <= 3'd0;
      r_load    <= 1'b0;
      r_running <= 1'b0;
      r_err     <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count_next;
      r_load    <= (w_next == ST_LOAD);
      r_running <= (w_next == ST_LOCKED);
      r_err     <= w_err_next;
      r_abort   <= w_abort_next;
    end
  end

  assign min_tens    = w_digits[3];
  assign min_ones    = w_digits[2];
  assign sec_tens    = w_digits[1];
  assign sec_ones    = w_digits[0];
  assign load        = r_load;
  assign running     = r_running;
  assign entry_count = r_count;
  assign err         = r_err;
  assign abort       = r_abort;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader. Stimulus pushes the expected pulse
// (err / load / abort with the digits expected alongside it) into a queue; a
// negedge monitor pops and compares whenever the DUT raises any pulse.
module tb_time_entry_loader;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       run_done = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       load, running, err, abort;
  logic [2:0] entry_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  flags;   // {load, abort, err}
    logic [15:0] digits;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  time_entry_loader dut (
    .clk         (clk),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .cancel      (cancel),
    .run_done    (run_done),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .load        (load),
    .running     (running),
    .entry_count (entry_count),
    .err         (err),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  wire [15:0] digits = {min_tens, min_ones, sec_tens, sec_ones};

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clear && (load || abort || err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got load/abort/err=%b digits=%h, required no pulse",
                 {load, abort, err}, digits);
      end else begin
        mon_e = exp_q.pop_front();
        if ({load, abort, err} !== mon_e.flags || digits !== mon_e.digits || running !== 1'b0) begin
          errors++;
          $display("FAIL pulse: got load/abort/err=%b digits=%h running=%b, required %b digits=%h running=0",
                   {load, abort, err}, digits, running, mon_e.flags, mon_e.digits);
        end
      end
    end
  end

  task automatic expect_pulse(input logic [2:0] flags, input logic [15:0] d);
    exp_t e;
    e.flags  = flags;
    e.digits = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock with the given strobes; returns at posedge+1 with strobes low.
  task automatic step(input logic kv, input logic [3:0] kd, input logic st,
                      input logic cn, input logic rd);
    key_valid = kv;
    key_digit = kd;
    start     = st;
    cancel    = cn;
    run_done  = rd;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_digit = 4'd0;
    start     = 1'b0;
    cancel    = 1'b0;
    run_done  = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_digits", {16'h0, digits}, 32'h0000);
    chk("rst_flags", {28'h0, load, running, err, abort}, 32'h0);
    chk("rst_count", {29'h0, entry_count}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    idle();

    // Keys 1,3,0 then start -> load 0130, run, run_done
    press(4'd1);
    press(4'd3);
    press(4'd0);
    chk("t1_digits", {16'h0, digits}, 32'h0130);
    chk("t1_count", {29'h0, entry_count}, 32'd3);
    expect_pulse(3'b100, 16'h0130);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("t1_load_cycle", {30'h0, load, running}, 32'b10);
    idle();
    chk("t1_running", {30'h0, load, running}, 32'b01);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("t1_done_running", {31'h0, running}, 32'd0);
    chk("t1_done_digits", {16'h0, digits}, 32'h0000);
    chk("t1_done_count", {29'h0, entry_count}, 32'd0);

    // Five keys: fifth rejected, buffer stays 1234
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    expect_pulse(3'b001, 16'h1234);
    press(4'd5);
    chk("t2_digits", {16'h0, digits}, 32'h1234);
    chk("t2_count", {29'h0, entry_count}, 32'd4);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("t2_cancel_digits", {16'h0, digits}, 32'h0000);

    // Illegal key code, then 0099 fails seconds-tens validation
    expect_pulse(3'b001, 16'h0000);
    press(4'd12);
    chk("t3_badkey_count", {29'h0, entry_count}, 32'd0);
    press(4'd0);
    press(4'd9);
    press(4'd9);
    expect_pulse(3'b001, 16'h0099);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t3_still_entry", {16'h0, digits}, 32'h0099);
    chk("t3_count", {29'h0, entry_count}, 32'd3);
    chk("t3_not_running", {31'h0, running}, 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Start in IDLE, and start on an all-zero buffer
    expect_pulse(3'b001, 16'h0000);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    press(4'd0);
    press(4'd0);
    chk("t4_zero_count", {29'h0, entry_count}, 32'd2);
    expect_pulse(3'b001, 16'h0000);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Run 0010, keys/start ignored while locked, cancel aborts
    press(4'd1);
    press(4'd0);
    expect_pulse(3'b100, 16'h0010);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    press(4'd3);
    chk("t5_locked_digits", {16'h0, digits}, 32'h0010);
    chk("t5_locked_running", {31'h0, running}, 32'd1);
    expect_pulse(3'b010, 16'h0000);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_abort_running", {31'h0, running}, 32'd0);
    chk("t5_abort_count", {29'h0, entry_count}, 32'd0);
    idle();
    chk("t5_abort_one_cycle", {31'h0, abort}, 32'd0);

    // Start and key 7 together: start wins, key dropped silently
    press(4'd5);
    expect_pulse(3'b100, 16'h0005);
    step(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    idle();
    chk("t6_digits", {16'h0, digits}, 32'h0005);
    chk("t6_running", {31'h0, running}, 32'd1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Cancel and start together: back to IDLE, no load
    press(4'd3);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    idle();
    chk("t7_digits", {16'h0, digits}, 32'h0000);
    chk("t7_flags", {28'h0, load, running, err, abort}, 32'h0);

    // clear asserted during LOAD: outputs drop immediately
    press(4'd4);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL t8_load_before_clear: got %b, required 1", load);
    end
    #1;
    clear = 1'b0;
    #1;
    chk("t8_clear_flags", {28'h0, load, running, err, abort}, 32'h0);
    chk("t8_clear_digits", {16'h0, digits}, 32'h0000);
    chk("t8_clear_count", {29'h0, entry_count}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b1;
    idle();
    idle();
    chk("all_pulses_seen", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
